// File: rtl/fu_writeback_arbiter.sv
// Writeback arbiter: buffers FU completion packets in per-FU FIFOs and
// retires up to WB_PORTS of them per cycle, round-robin, onto registered
// PRF write / wakeup / ROB completion ports.
module fu_writeback_arbiter #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4,
    parameter int WB_PORTS     = 2,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fu_in_valid          [FU_COUNT],
    output logic                    fu_in_ready          [FU_COUNT],
    input  logic [INST_ID_BITS-1:0] fu_in_inst_id        [FU_COUNT],
    input  logic [PRN_BITS-1:0]     fu_in_prn            [FU_COUNT][MAX_OPERANDS],
    input  logic [63:0]             fu_in_data           [FU_COUNT][MAX_OPERANDS],
    input  logic                    fu_in_data_valid     [FU_COUNT][MAX_OPERANDS],
    output logic                    prf_write_enable     [WB_PORTS][MAX_OPERANDS],
    output logic [PRN_BITS-1:0]     prf_write_prn        [WB_PORTS][MAX_OPERANDS],
    output logic [63:0]             prf_write_data       [WB_PORTS][MAX_OPERANDS],
    output logic                    set_prn_ready        [WB_PORTS][MAX_OPERANDS],
    output logic [PRN_BITS-1:0]     set_prn              [WB_PORTS][MAX_OPERANDS],
    output logic                    rob_complete_valid   [WB_PORTS],
    output logic [INST_ID_BITS-1:0] rob_complete_inst_id [WB_PORTS]
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int RR_W  = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

    typedef struct packed {
        logic [INST_ID_BITS-1:0]                  inst_id;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    prn;
        logic [MAX_OPERANDS-1:0][63:0]            data;
        logic [MAX_OPERANDS-1:0]                  dv;
    } pkt_t;

    pkt_t             mem_q    [FU_COUNT][FIFO_DEPTH];
    pkt_t             mem_d    [FU_COUNT][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [FU_COUNT];
    logic [PTR_W-1:0] wr_ptr_d [FU_COUNT];
    logic [PTR_W-1:0] rd_ptr_q [FU_COUNT];
    logic [PTR_W-1:0] rd_ptr_d [FU_COUNT];
    logic [CNT_W-1:0] count_q  [FU_COUNT];
    logic [CNT_W-1:0] count_d  [FU_COUNT];
    logic [RR_W-1:0]  rr_ptr_q;
    logic [RR_W-1:0]  rr_ptr_d;
    logic             wb_vld_q [WB_PORTS];
    logic             wb_vld_d [WB_PORTS];
    pkt_t             wb_pkt_q [WB_PORTS];
    pkt_t             wb_pkt_d [WB_PORTS];

    logic             push     [FU_COUNT];
    logic             pop      [FU_COUNT];
    pkt_t             in_pkt   [FU_COUNT];

    // Ready depends only on the registered count, so a full FIFO stays
    // not-ready even in a cycle where it is being popped.
    always_comb begin
        for (int i = 0; i < FU_COUNT; i++) begin
            fu_in_ready[i]    = (count_q[i] != CNT_W'(FIFO_DEPTH));
            push[i]           = fu_in_valid[i] && (count_q[i] != CNT_W'(FIFO_DEPTH));
            in_pkt[i]         = '0;
            in_pkt[i].inst_id = fu_in_inst_id[i];
            for (int j = 0; j < MAX_OPERANDS; j++) begin
                in_pkt[i].prn[j]  = fu_in_prn[i][j];
                in_pkt[i].data[j] = fu_in_data[i][j];
                in_pkt[i].dv[j]   = fu_in_data_valid[i][j];
            end
        end
    end

    // Round-robin scan from rr_ptr; the k-th non-empty FIFO found goes to port k.
    always_comb begin
        int          n_grant;
        int          last;
        logic [RR_W:0] sum;
        n_grant  = 0;
        last     = 0;
        sum      = '0;
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < FU_COUNT; i++) pop[i] = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_vld_d[p] = 1'b0;
            wb_pkt_d[p] = '0;
        end
        for (int k = 0; k < FU_COUNT; k++) begin
            sum = {1'b0, rr_ptr_q} + (RR_W+1)'(k);
            if (sum >= (RR_W+1)'(FU_COUNT)) sum = sum - (RR_W+1)'(FU_COUNT);
            for (int i = 0; i < FU_COUNT; i++) begin
                if ((RR_W+1)'(i) == sum && count_q[i] != '0 && n_grant < WB_PORTS) begin
                    pop[i] = 1'b1;
                    for (int p = 0; p < WB_PORTS; p++) begin
                        if (p == n_grant) begin
                            wb_vld_d[p] = 1'b1;
                            wb_pkt_d[p] = mem_q[i][rd_ptr_q[i]];
                        end
                    end
                    n_grant = n_grant + 1;
                    last    = i;
                end
            end
        end
        if (n_grant != 0) begin
            rr_ptr_d = (last == FU_COUNT - 1) ? '0 : RR_W'(last + 1);
        end
    end

    // Per-FU FIFO bookkeeping; pointers wrap naturally since depth is a power of two.
    always_comb begin
        for (int i = 0; i < FU_COUNT; i++) begin
            for (int e = 0; e < FIFO_DEPTH; e++) mem_d[i][e] = mem_q[i][e];
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            count_d[i]  = count_q[i];
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_pkt[i];
                wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
            end
            if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            if (push[i] && !pop[i])      count_d[i] = count_q[i] + CNT_W'(1);
            else if (!push[i] && pop[i]) count_d[i] = count_q[i] - CNT_W'(1);
        end
    end

    // Control and writeback registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < FU_COUNT; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            for (int p = 0; p < WB_PORTS; p++) begin
                wb_vld_q[p] <= 1'b0;
                wb_pkt_q[p] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wb_vld_q <= wb_vld_d;
            wb_pkt_q <= wb_pkt_d;
        end
    end

    // FIFO storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Fan the registered packet out to PRF, wakeup and ROB ports.
    always_comb begin
        for (int p = 0; p < WB_PORTS; p++) begin
            rob_complete_valid[p]   = wb_vld_q[p];
            rob_complete_inst_id[p] = wb_pkt_q[p].inst_id;
            for (int j = 0; j < MAX_OPERANDS; j++) begin
                prf_write_enable[p][j] = wb_pkt_q[p].dv[j];
                set_prn_ready[p][j]    = wb_pkt_q[p].dv[j];
                prf_write_prn[p][j]    = wb_pkt_q[p].prn[j];
                set_prn[p][j]          = wb_pkt_q[p].prn[j];
                prf_write_data[p][j]   = wb_pkt_q[p].data[j];
            end
        end
    end

endmodule

// File: tb/tb_fu_writeback_arbiter.sv
// Bench for fu_writeback_arbiter: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_fu_writeback_arbiter;

    localparam int NFU   = 4;
    localparam int NWB   = 2;
    localparam int NOP   = 3;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [5:0]        id;
        logic [2:0][5:0]   prn;
        logic [2:0][63:0]  data;
        logic [2:0]        dv;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fu_in_valid          [NFU];
    logic        fu_in_ready          [NFU];
    logic [5:0]  fu_in_inst_id        [NFU];
    logic [5:0]  fu_in_prn            [NFU][NOP];
    logic [63:0] fu_in_data           [NFU][NOP];
    logic        fu_in_data_valid     [NFU][NOP];
    logic        prf_write_enable     [NWB][NOP];
    logic [5:0]  prf_write_prn        [NWB][NOP];
    logic [63:0] prf_write_data       [NWB][NOP];
    logic        set_prn_ready        [NWB][NOP];
    logic [5:0]  set_prn              [NWB][NOP];
    logic        rob_complete_valid   [NWB];
    logic [5:0]  rob_complete_inst_id [NWB];

    fu_writeback_arbiter dut (
        .clk                  (clk),
        .rst                  (rst),
        .fu_in_valid          (fu_in_valid),
        .fu_in_ready          (fu_in_ready),
        .fu_in_inst_id        (fu_in_inst_id),
        .fu_in_prn            (fu_in_prn),
        .fu_in_data           (fu_in_data),
        .fu_in_data_valid     (fu_in_data_valid),
        .prf_write_enable     (prf_write_enable),
        .prf_write_prn        (prf_write_prn),
        .prf_write_data       (prf_write_data),
        .set_prn_ready        (set_prn_ready),
        .set_prn              (set_prn),
        .rob_complete_valid   (rob_complete_valid),
        .rob_complete_inst_id (rob_complete_inst_id)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    pkt_t mq [NFU][$];
    int   rr_m;
    logic exp_vld [NWB];
    pkt_t exp_pkt [NWB];

    // Stimulus for the next cycle
    logic drv_rst;
    logic drv_valid [NFU];
    pkt_t drv_pkt   [NFU];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pkt_t rand_pkt();
        pkt_t p;
        p.id = 6'($urandom);
        for (int j = 0; j < NOP; j++) begin
            p.prn[j]  = 6'($urandom);
            p.data[j] = {32'($urandom), 32'($urandom)};
        end
        p.dv = 3'($urandom);
        return p;
    endfunction

    task automatic clear_drive();
        drv_rst = 1'b0;
        for (int i = 0; i < NFU; i++) begin
            drv_valid[i] = 1'b0;
            drv_pkt[i]   = '0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NFU; i++) mq[i].delete();
        rr_m = 0;
        for (int p = 0; p < NWB; p++) begin
            exp_vld[p] = 1'b0;
            exp_pkt[p] = '0;
        end
    endtask

    task automatic check_outputs();
        for (int p = 0; p < NWB; p++) begin
            chk($sformatf("rob_valid[%0d]", p), 64'(rob_complete_valid[p]), 64'(exp_vld[p]));
            chk($sformatf("rob_id[%0d]", p), 64'(rob_complete_inst_id[p]), 64'(exp_pkt[p].id));
            for (int j = 0; j < NOP; j++) begin
                chk($sformatf("prf_we[%0d][%0d]", p, j), 64'(prf_write_enable[p][j]),
                    64'(exp_vld[p] & exp_pkt[p].dv[j]));
                chk($sformatf("wakeup_vld[%0d][%0d]", p, j), 64'(set_prn_ready[p][j]),
                    64'(exp_vld[p] & exp_pkt[p].dv[j]));
                chk($sformatf("prf_prn[%0d][%0d]", p, j), 64'(prf_write_prn[p][j]), 64'(exp_pkt[p].prn[j]));
                chk($sformatf("set_prn[%0d][%0d]", p, j), 64'(set_prn[p][j]), 64'(exp_pkt[p].prn[j]));
                chk($sformatf("prf_data[%0d][%0d]", p, j), prf_write_data[p][j], exp_pkt[p].data[j]);
            end
        end
        for (int i = 0; i < NFU; i++) begin
            chk($sformatf("ready[%0d]", i), 64'(fu_in_ready[i]), 64'(mq[i].size() < DEPTH));
        end
    endtask

    // Called at a negedge: check what is visible now, drive the next inputs,
    // advance the model across the coming posedge, then wait for the next negedge.
    task automatic cycle();
        logic acc [NFU];
        int   ng;
        int   last;
        int   fu;
        check_outputs();
        rst = drv_rst;
        for (int i = 0; i < NFU; i++) begin
            fu_in_valid[i]   = drv_valid[i];
            fu_in_inst_id[i] = drv_pkt[i].id;
            for (int j = 0; j < NOP; j++) begin
                fu_in_prn[i][j]        = drv_pkt[i].prn[j];
                fu_in_data[i][j]       = drv_pkt[i].data[j];
                fu_in_data_valid[i][j] = drv_pkt[i].dv[j];
            end
        end
        if (drv_rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NFU; i++) acc[i] = drv_valid[i] && (mq[i].size() < DEPTH);
            for (int p = 0; p < NWB; p++) begin
                exp_vld[p] = 1'b0;
                exp_pkt[p] = '0;
            end
            ng   = 0;
            last = 0;
            for (int k = 0; k < NFU; k++) begin
                fu = (rr_m + k) % NFU;
                if (mq[fu].size() > 0 && ng < NWB) begin
                    exp_pkt[ng] = mq[fu].pop_front();
                    exp_vld[ng] = 1'b1;
                    ng++;
                    last = fu;
                end
            end
            if (ng > 0) rr_m = (last + 1) % NFU;
            for (int i = 0; i < NFU; i++) if (acc[i]) mq[i].push_back(drv_pkt[i]);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        clear_drive();
        repeat (n) cycle();
    endtask

    initial begin
        pkt_t p;
        clear_drive();
        for (int i = 0; i < NFU; i++) begin
            fu_in_valid[i]   = 1'b0;
            fu_in_inst_id[i] = '0;
            for (int j = 0; j < NOP; j++) begin
                fu_in_prn[i][j]        = '0;
                fu_in_data[i][j]       = '0;
                fu_in_data_valid[i][j] = 1'b0;
            end
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Single packet from FU1
        idle(1);
        p = '0;
        p.id = 6'd5; p.prn[0] = 6'd7; p.data[0] = 64'h1234; p.dv = 3'b001;
        clear_drive();
        drv_valid[1] = 1'b1; drv_pkt[1] = p;
        cycle();
        idle(4);

        // All four FUs at once
        clear_drive();
        for (int i = 0; i < NFU; i++) begin
            drv_valid[i] = 1'b1;
            drv_pkt[i]   = rand_pkt();
        end
        cycle();
        idle(4);

        // Completion without any result data
        p = rand_pkt();
        p.id = 6'd12; p.dv = 3'b000;
        clear_drive();
        drv_valid[2] = 1'b1; drv_pkt[2] = p;
        cycle();
        idle(3);

        // Pointer wrap: FU2 alone moves rr to 3, then FU0 and FU3 together
        clear_drive();
        drv_valid[2] = 1'b1; drv_pkt[2] = rand_pkt();
        cycle();
        clear_drive();
        drv_valid[0] = 1'b1; drv_pkt[0] = rand_pkt();
        drv_valid[3] = 1'b1; drv_pkt[3] = rand_pkt();
        cycle();
        idle(4);

        // Backpressure: all FUs back-to-back for 6 cycles, then drain
        for (int c = 0; c < 6; c++) begin
            clear_drive();
            for (int i = 0; i < NFU; i++) begin
                drv_valid[i] = 1'b1;
                drv_pkt[i]   = rand_pkt();
            end
            cycle();
        end
        idle(12);

        // Mid-flight reset with packets buffered
        for (int c = 0; c < 2; c++) begin
            clear_drive();
            for (int i = 0; i < NFU; i++) begin
                drv_valid[i] = 1'b1;
                drv_pkt[i]   = rand_pkt();
            end
            cycle();
        end
        clear_drive();
        drv_rst = 1'b1;
        drv_valid[0] = 1'b1; drv_pkt[0] = rand_pkt();
        cycle();
        idle(5);

        // Random traffic with varying load and occasional resets
        for (int c = 0; c < 600; c++) begin
            int load;
            load = (c / 100) % 3;
            clear_drive();
            drv_rst = ($urandom_range(0, 79) == 0);
            for (int i = 0; i < NFU; i++) begin
                case (load)
                    0:       drv_valid[i] = ($urandom_range(0, 3) == 0);
                    1:       drv_valid[i] = ($urandom_range(0, 1) == 0);
                    default: drv_valid[i] = ($urandom_range(0, 7) != 0);
                endcase
                drv_pkt[i] = rand_pkt();
            end
            cycle();
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
